// File: rtl/matmul_pkg.sv
// Shared definitions for the streaming NxN matrix multiplier: FSM encoding
// and the width helpers used to size the result datapath.
package matmul_pkg;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    COMP = 2'd1,
    OUT  = 2'd2
  } state_t;

  function automatic int clog2(input int value);
    int bits;
    bits = 0;
    for (int p = 1; p < value; p = p * 2) bits++;
    return bits;
  endfunction

  // Wide enough that a full N-term dot product can never overflow.
  function automatic int acc_width(input int bit_width, input int n);
    return 2 * bit_width + clog2(n);
  endfunction

endpackage

// File: rtl/matmul_row_engine.sv
// Two-stage row engine: registered N*N products for one A row against the
// whole B buffer, then a per-column adder tree producing one C row.
module matmul_row_engine
  import matmul_pkg::*;
#(
  parameter int N        = 3,
  parameter int BitWidth = 8,
  parameter int SIGNED   = 0,
  parameter int AccWidth = acc_width(BitWidth, N),
  parameter int IdxW     = clog2(N)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic                         issue,
  input  logic [IdxW-1:0]              row_idx,
  input  logic [N*BitWidth-1:0]        a_row,
  input  logic [N-1:0][N*BitWidth-1:0] b_mat,
  output logic [N*AccWidth-1:0]        c_row,
  output logic [IdxW-1:0]              c_idx,
  output logic                         c_vld
);

  logic signed [AccWidth-1:0] prod_p1 [N][N];
  logic        [IdxW-1:0]     idx_p1;
  logic                       vld_p1;

  function automatic logic signed [AccWidth-1:0] extend(input logic [BitWidth-1:0] x);
    if (SIGNED != 0) return AccWidth'($signed(x));
    return AccWidth'(x);
  endfunction

  // Pairwise reduction, log2(N) adder levels deep.
  function automatic logic signed [AccWidth-1:0] tree_sum(
    input logic signed [AccWidth-1:0] terms [N]
  );
    logic signed [AccWidth-1:0] w [N];
    w = terms;
    for (int s = 1; s < N; s = s * 2)
      for (int i = 0; i + s < N; i = i + 2 * s)
        w[i] = w[i] + w[i+s];
    return w[0];
  endfunction

  // Stage 1: multiply, prod_p1[j][k] = A[r][k] * B[k][j]
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) vld_p1 <= 1'b0;
    else if (enable) vld_p1 <= issue;
  end

  always_ff @(posedge clk) begin
    if (enable && issue) begin
      idx_p1 <= row_idx;
      for (int j = 0; j < N; j++)
        for (int k = 0; k < N; k++)
          prod_p1[j][k] <= extend(a_row[k*BitWidth +: BitWidth]) *
                           extend(b_mat[k][j*BitWidth +: BitWidth]);
    end
  end

  // Stage 2: column adder trees, captured by the C buffer in the parent
  always_comb begin
    c_row = '0;
    for (int j = 0; j < N; j++)
      c_row[j*AccWidth +: AccWidth] = tree_sum(prod_p1[j]);
  end

  assign c_idx = idx_p1;
  assign c_vld = vld_p1;

endmodule

// File: rtl/matrix_mult_stream.sv
// Streaming C = A x B: rows of A and B arrive one pair per beat, rows of C
// leave one per beat, both on valid/ready; a new load never overlaps output.
module matrix_mult_stream
  import matmul_pkg::*;
#(
  parameter int N        = 3,
  parameter int BitWidth = 8,
  parameter int SIGNED   = 0,
  parameter int AccWidth = acc_width(BitWidth, N)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [N*BitWidth-1:0] in_a_row,
  input  logic [N*BitWidth-1:0] in_b_row,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [N*AccWidth-1:0] out_row,
  output logic                  out_last,
  output logic                  busy
);

  localparam int IdxW = clog2(N);
  localparam int CntW = clog2(N + 1);

  state_t                       state;
  logic [CntW-1:0]              cnt;
  logic [IdxW-1:0]              idx;
  logic [N-1:0][N*BitWidth-1:0] a_buf;
  logic [N-1:0][N*BitWidth-1:0] b_buf;
  logic [N*AccWidth-1:0]        c_buf [N];
  logic                         take;
  logic                         issue;
  logic                         row_done;
  logic [N*AccWidth-1:0]        c_row;
  logic [IdxW-1:0]              c_idx;
  logic                         c_vld;

  // cnt counts beats in LOAD, issued rows (0..N) in COMP, output rows in OUT.
  assign idx      = cnt[IdxW-1:0];
  assign in_ready = reset && enable && (state == LOAD);
  assign take     = in_valid && in_ready;
  assign issue    = (state == COMP) && (cnt != CntW'(N));
  assign row_done = enable && c_vld;

  matmul_row_engine #(
    .N        (N),
    .BitWidth (BitWidth),
    .SIGNED   (SIGNED),
    .AccWidth (AccWidth),
    .IdxW     (IdxW)
  ) u_engine (
    .clk     (clk),
    .reset   (reset),
    .enable  (enable),
    .issue   (issue),
    .row_idx (idx),
    .a_row   (a_buf[idx]),
    .b_mat   (b_buf),
    .c_row   (c_row),
    .c_idx   (c_idx),
    .c_vld   (c_vld)
  );

  always_ff @(posedge clk) begin
    if (take) begin
      a_buf[idx] <= in_a_row;
      b_buf[idx] <= in_b_row;
    end
    if (row_done) c_buf[c_idx] <= c_row;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= LOAD;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      out_row   <= '0;
    end else begin
      case (state)
        LOAD: begin
          if (take) begin
            busy <= 1'b1;
            if (cnt == CntW'(N - 1)) begin
              state <= COMP;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        COMP: begin
          if (enable) begin
            if (issue) cnt <= cnt + 1'b1;
            // C[0] was written N-1 edges earlier, so it is safe to present now.
            if (row_done && c_idx == IdxW'(N - 1)) begin
              state     <= OUT;
              cnt       <= '0;
              out_valid <= 1'b1;
              out_last  <= 1'b0;
              out_row   <= c_buf[0];
            end
          end
        end
        OUT: begin
          if (out_ready) begin
            if (out_last) begin
              state     <= LOAD;
              cnt       <= '0;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              busy      <= 1'b0;
            end else begin
              cnt      <= cnt + 1'b1;
              out_row  <= c_buf[idx + 1'b1];
              out_last <= (cnt == CntW'(N - 2));
            end
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: doc/matrix_mult_stream.md
Name: matrix_mult_stream

Overview:
- Parametrised NxN successor to the fixed 3x3 flattened-port multiplier: C = A x B for any N and BitWidth, with optional signed arithmetic.
- Operands stream in one row-pair per beat and results stream out one row per beat, both on valid/ready handshakes, so the block sits directly on a datapath bus instead of taking N*N parallel ports.
- Internal two-stage pipelined row engine: N*N multipliers per row, followed by an N-input adder tree per column.

Parameters:
- N, 3, matrix dimension (N >= 2).
- BitWidth, 8, operand element width.
- SIGNED, 0, 1 means elements are two's complement, 0 means unsigned.
- AccWidth, 2*BitWidth+$clog2(N), result element width; sums never overflow.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  gates LOAD and COMP progress; when low the block holds in those states.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block accepts an input beat.
- in_a_row  in  N*BitWidth  row k of A; element j at bits [j*BitWidth +: BitWidth].
- in_b_row  in  N*BitWidth  row k of B; same packing as in_a_row.
- out_valid  out  1  result row valid.
- out_ready  in  1  downstream accepts the result row.
- out_row  out  N*AccWidth  row r of C; element j at bits [j*AccWidth +: AccWidth].
- out_last  out  1  high with row N-1 of C.
- busy  out  1  high in COMP and OUT, and in LOAD once at least one beat has been taken.

Behaviour:
- reset low (asynchronous): state=LOAD; row and beat counters=0; pipeline valids=0; in_ready=0, out_valid=0, out_last=0, busy=0; out_row=0; A, B, C buffers are not cleared.
- LOAD: in_ready = enable. Beat k is taken on an edge with in_valid&in_ready; it writes A[k][*] and B[k][*], then k increments. The edge that takes beat N-1 moves state to COMP with k=0.
- COMP: lasts exactly N+1 enabled edges.
  - Edges 0..N-1: issue row r. Stage 1 registers P[j][k] = A[r][k]*B[k][j] for all j,k, sign- or zero-extended to AccWidth per SIGNED.
  - The following edge: stage 2 writes C[r][j] = sum over k of P[j][k].
  - The edge that writes C[N-1] moves state to OUT with r=0.
  - in_ready=0 throughout.
- enable low in LOAD or COMP: every register holds and in_ready=0.
- OUT: not affected by enable.
  - out_valid=1, out_row=C[r], out_last=(r==N-1).
  - On valid&ready, r increments. out_valid never drops while waiting for ready.
  - The transfer with out_last moves state to LOAD with k=0 and busy=0.
  - in_ready=0 throughout, so the next matrix is never overlapped.
- Latency: first beat taken at edge 0, last beat at edge N-1; out_valid rises after edge 2N with enable held high. For N=3 that is 7 edges, and the minimum throughput period is 3N+1 edges.
- Boundaries:
  - in_valid high outside LOAD: ignored; the beat is not consumed.
  - out_ready held low: the block stalls in OUT indefinitely with out_row stable.
  - reset asserted mid-LOAD, mid-COMP or mid-OUT: immediate return to the reset state; the partial matrix is discarded and no further out_valid appears until a full new load completes.
  - Arithmetic is exact: the AccWidth sizing rules out overflow. SIGNED=1 uses signed multiply and signed add.

Decomposition:
- Shared package matmul_pkg holds:
  - State encoding: LOAD=2'd0, COMP=2'd1, OUT=2'd2.
  - A clog2 helper function.
  - The AccWidth formula as a function of BitWidth and N.
- One sub-module, matmul_row_engine. It takes one A row and the full B buffer, contains the two pipeline stages (multiply, adder tree), and returns the C row plus a valid flag. The top level owns the FSM, counters, buffers and handshakes.

Test Plan:
- Reference matrices, N=3, BitWidth=8, unsigned: A=1..9, B=9..1, both row-major. out_valid rises 7 edges after the first beat, then rows are 30 24 18 / 84 69 54 / 138 114 90, with out_last on the third row.
- All elements 255 with N=3: every C element is 195075 and fits AccWidth=18.
- SIGNED=1, all elements -128: every C element is 49152. A row 0 = (-1,2,-3) times B = identity gives C row 0 = (-1,2,-3).
- out_ready pseudo-random with roughly 50% duty: out_valid is never withdrawn before its transfer, rows arrive in order with correct values, and in_ready stays 0 until after the out_last transfer.
- enable dropped for 5 cycles mid-LOAD and mid-COMP: results are unchanged and latency grows by exactly 5 per gap. in_valid held high during OUT: no beat is consumed.
- reset pulsed low during COMP of matrix 1: all outputs are 0 immediately. A second full load (identity x B) then produces exactly B, with no residue from matrix 1. Two back-to-back matrices each produce their correct result.
